// File: rtl/mips32_pkg.sv
// Shared types and constants for the mips32 data-memory responder.
// Holds the FSM state encoding and the captured request layout.
package mips32_pkg;

  localparam int WORD_BYTES      = 4;
  localparam int MAX_WAIT_STATES = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
  } req_t;

endpackage

// File: rtl/mips32_dmem_ram.sv
// Single-port word RAM, byte-lane writes, registered read.
// Read data holds its value until the next enabled load; no reset on contents.
module mips32_dmem_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clock,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       byte_en_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (byte_en_i[i]) mem[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips32_dmem_responder.sv
// Load/store responder with WAIT_STATES+1 cycle latency; holds response until resp_ready.
// Optional handshake counters when MIPS32_DMEM_STATS_EN is defined.
module mips32_dmem_responder
  import mips32_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_byte_en,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
`ifdef MIPS32_DMEM_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errors
`endif
);

  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS * WORD_BYTES);
  localparam logic [3:0]  WS_LAST = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        load_q, load_d;
  logic        err_q, err_d;

  req_t        in_req, cur_req;
  logic [31:0] offset;
  logic        cur_err;
  logic        enter_resp;
  logic        ram_en;
  logic [31:0] ram_rdata;

  assign in_req = '{write: req_write, addr: req_addr, wdata: req_wdata, byte_en: req_byte_en};
  // With zero wait states the RAM is accessed on the accept edge, before req_q is loaded.
  assign cur_req = (state_q == IDLE) ? in_req : req_q;
  assign offset  = cur_req.addr - ADDR_BASE;
  assign cur_err = (cur_req.addr[1:0] != 2'b00) || (offset >= SPAN);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    load_d     = load_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d = in_req;
          cnt_d = 4'd0;
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == WS_LAST) begin
          state_d    = RESP;
          cnt_d      = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
          load_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      load_d = !cur_req.write && !cur_err;
      err_d  = cur_err;
    end
  end

  // Gating with reset drops a store whose write edge coincides with reset.
  assign ram_en = enter_resp && !cur_err && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= 4'd0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  mips32_dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clock    (clock),
    .en_i     (ram_en),
    .we_i     (cur_req.write),
    .idx_i    (offset[IDX_W+1:2]),
    .wdata_i  (cur_req.wdata),
    .byte_en_i(cur_req.byte_en),
    .rdata_o  (ram_rdata)
  );

  assign resp_rdata = load_q ? ram_rdata : 32'h0;
  assign resp_error = err_q;

`ifdef MIPS32_DMEM_STATS_EN
  logic [15:0] loads_q, stores_q, errors_q;
  logic        hs;

  assign hs = (state_q == RESP) && resp_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      loads_q  <= 16'h0;
      stores_q <= 16'h0;
      errors_q <= 16'h0;
    end else if (hs) begin
      if (err_q) begin
        if (errors_q != 16'hFFFF) errors_q <= errors_q + 16'h1;
      end else if (load_q) begin
        if (loads_q != 16'hFFFF) loads_q <= loads_q + 16'h1;
      end else begin
        if (stores_q != 16'hFFFF) stores_q <= stores_q + 16'h1;
      end
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errors = errors_q;
`endif

endmodule

// File: tb/tb_mips32_dmem_responder.sv
// Directed bench: WAIT_STATES=2 instance plus a WAIT_STATES=0 instance (stats when enabled).
module tb_mips32_dmem_responder;

  logic        clock = 1'b0;
  logic        reset;

  logic        req_valid, req_write, req_ready, resp_valid, resp_ready, resp_error;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0]  req_byte_en;

  logic        z_req_valid, z_req_write, z_req_ready, z_resp_valid, z_resp_ready, z_resp_error;
  logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;
  logic [3:0]  z_req_byte_en;

`ifdef MIPS32_DMEM_STATS_EN
  logic [15:0] s_loads, s_stores, s_errors;
  logic [15:0] z_loads, z_stores, z_errors;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mips32_dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .ADDR_BASE(32'h0)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_byte_en(req_byte_en), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error)
`ifdef MIPS32_DMEM_STATS_EN
    , .stat_loads(s_loads), .stat_stores(s_stores), .stat_errors(s_errors)
`endif
  );

  mips32_dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .ADDR_BASE(32'h0)) dut0 (
    .clock(clock), .reset(reset),
    .req_valid(z_req_valid), .req_write(z_req_write), .req_addr(z_req_addr),
    .req_wdata(z_req_wdata), .req_byte_en(z_req_byte_en), .req_ready(z_req_ready),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata),
    .resp_error(z_resp_error)
`ifdef MIPS32_DMEM_STATS_EN
    , .stat_loads(z_loads), .stat_stores(z_stores), .stat_errors(z_errors)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issues one request on dut, returns cycles from accept edge to resp_valid.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output int lat,
                        output logic [31:0] rd, output logic e);
    int guard = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_byte_en = be;
    while (!req_ready && guard < 50) begin step(); guard++; end
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin step(); lat++; end
    rd = resp_rdata; e = resp_error;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic do_req0(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output int lat,
                         output logic [31:0] rd, output logic e);
    int guard = 0;
    z_req_valid = 1'b1; z_req_write = w; z_req_addr = a; z_req_wdata = d; z_req_byte_en = be;
    while (!z_req_ready && guard < 50) begin step(); guard++; end
    step();
    z_req_valid = 1'b0;
    lat = 1;
    while (!z_resp_valid && lat < 50) begin step(); lat++; end
    rd = z_resp_rdata; e = z_resp_error;
    z_resp_ready = 1'b1;
    step();
    z_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", resp_error); end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic e;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, e);
    checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency got=%0d exp=3", lat); end
    checks++; if (e !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL store_resp got=%b/%h exp=0/0", e, rd); end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, e);
    checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL load_data got=%h/%b exp=deadbeef/0", rd, e); end
  endtask

  task automatic test_partial_store();
    int lat; logic [31:0] rd; logic e;
    do_req(1'b1, 32'h10, 32'h0000AA00, 4'b0010, lat, rd, e);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, e);
    checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL partial_store got=%h exp=deadaaef", rd); end
    do_req(1'b1, 32'h14, 32'h55555555, 4'h0, lat, rd, e);
    do_req(1'b1, 32'h14, 32'h01020304, 4'hF, lat, rd, e);
    do_req(1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, lat, rd, e);
    do_req(1'b0, 32'h14, 32'h0, 4'h0, lat, rd, e);
    checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL zero_byte_en got=%h exp=01020304", rd); end
  endtask

  task automatic test_backpressure();
    int guard = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_byte_en = 4'h0;
    step();
    req_addr = 32'h14;
    while (!resp_valid && guard < 50) begin step(); guard++; end
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_timeout got=%b exp=1", resp_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADAAEF || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d got v=%b d=%h rdy=%b exp v=1 d=deadaaef rdy=0",
                 i, resp_valid, resp_rdata, req_ready);
      end
      step();
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_after_hs got v=%b d=%h rdy=%b exp v=0 d=0 rdy=1", resp_valid, resp_rdata, req_ready);
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic e;
    do_req(1'b0, 32'h12, 32'h0, 4'h0, lat, rd, e);
    checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned got=%b/%h exp=1/0", e, rd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL err_latency got=%0d exp=3", lat); end
    do_req(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, lat, rd, e);
    do_req(1'b1, 32'h400, 32'h99999999, 4'hF, lat, rd, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL out_of_range got=%b exp=1", e); end
    do_req(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, e);
    checks++; if (rd !== 32'hCAFEF00D || e !== 1'b0) begin errors++; $display("FAIL word0_intact got=%h/%b exp=cafef00d/0", rd, e); end
    do_req(1'b0, 32'h3FC, 32'h0, 4'h0, lat, rd, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL last_word_err got=%b exp=0", e); end
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic [31:0] rd; logic e; logic seen = 1'b0;
    do_req(1'b1, 32'h20, 32'h11112222, 4'hF, lat, rd, e);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_byte_en = 4'hF;
    step();
    req_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) seen = 1'b1;
      step();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_resp got=%b exp=0", seen); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", req_ready); end
    do_req(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, e);
    checks++; if (rd !== 32'h11112222) begin errors++; $display("FAIL abort_store got=%h exp=11112222", rd); end
  endtask

  task automatic test_zero_wait();
    int lat; logic [31:0] rd; logic e;
    do_req0(1'b1, 32'h4, 32'hA5A5A5A5, 4'hF, lat, rd, e);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ws0_store_latency got=%0d exp=1", lat); end
    do_req0(1'b0, 32'h4, 32'h0, 4'h0, lat, rd, e);
    checks++; if (lat !== 1 || rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL ws0_load got=%0d/%h exp=1/a5a5a5a5", lat, rd); end
    do_req0(1'b1, 32'h4, 32'h00C30000, 4'b0100, lat, rd, e);
    do_req0(1'b0, 32'h4, 32'h0, 4'h0, lat, rd, e);
    checks++; if (rd !== 32'hA5C3A5A5) begin errors++; $display("FAIL ws0_partial got=%h exp=a5c3a5a5", rd); end
    do_req0(1'b0, 32'h3, 32'h0, 4'h0, lat, rd, e);
    checks++; if (e !== 1'b1 || rd !== 32'h0 || lat !== 1) begin errors++; $display("FAIL ws0_error got=%b/%h/%0d exp=1/0/1", e, rd, lat); end
`ifdef MIPS32_DMEM_STATS_EN
    checks++; if (z_loads !== 16'd2) begin errors++; $display("FAIL stat_loads got=%0d exp=2", z_loads); end
    checks++; if (z_stores !== 16'd2) begin errors++; $display("FAIL stat_stores got=%0d exp=2", z_stores); end
    checks++; if (z_errors !== 16'd1) begin errors++; $display("FAIL stat_errors got=%0d exp=1", z_errors); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_byte_en = '0; resp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_byte_en = '0; z_resp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_partial_store();
    test_backpressure();
    test_errors();
    test_reset_mid_wait();
    test_zero_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
